// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional build macro MCCTRL_ILLEGAL_TRAP_EN adds the TRAP state and trap output.
module multicycle_control #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 2,
    parameter int CNTW   = 16,
    parameter logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000),
    parameter logic [OPW-1:0] OP_LW    = OPW'(6'b100011),
    parameter logic [OPW-1:0] OP_SW    = OPW'(6'b101011),
    parameter logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100),
    parameter logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000),
    parameter logic [OPW-1:0] OP_J     = OPW'(6'b000010)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    output logic              pcwrite,
    output logic              pcwritecond,
    output logic              iord,
    output logic              memread,
    output logic              memwrite,
    output logic              irwrite,
    output logic              memtoreg,
    output logic              regdst,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [ALUOPW-1:0] aluop,
    output logic [1:0]        pcsrc,
    output logic [CNTW-1:0]   instr_count,
    output logic [3:0]        state
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ,
    output logic              trap
`endif
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;
    localparam logic [3:0] S_IDLE   = 4'd15;

    localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(2'b00);
    localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(2'b01);
    localparam logic [ALUOPW-1:0] ALU_FN  = ALUOPW'(2'b10);

    logic [3:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Next-state selection; undefined opcodes retire as no-ops or trap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)
                    state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)
                    state_d = S_EXEC;
                else if (opcode == OP_BEQ)
                    state_d = S_BRANCH;
                else if (opcode == OP_ADDI)
                    state_d = S_ADDIEX;
                else if (opcode == OP_J)
                    state_d = S_JUMP;
                else
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // An instruction retires whenever the FSM re-enters FETCH from a working state.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
            cnt_d = cnt_q + CNTW'(1);
    end

    // State and retire counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control strobes decoded from the current state only (plus fetch handshake).
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = ALU_ADD;
        pcsrc       = 2'b00;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALU_FN;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALU_SUB;
                pcsrc       = 2'b01;
                pcwritecond = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_count = cnt_q;
    assign state       = state_q;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign trap        = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction sequences plus random traffic
// checked every cycle against an instruction-level model of the control sequencing.
module tb_multicycle_control;

    localparam int CNTW = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef int iq_t[$];

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctl_t;

    logic clk = 1'b0;
    logic reset_n;
    logic [5:0] opcode;
    logic mem_ready;
    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [CNTW-1:0] instr_count;
    logic [3:0] state;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    logic trap;
`endif

    multicycle_control #(.CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .instr_count(instr_count), .state(state)
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        , .trap(trap)
`endif
    );

    always #5 clk = ~clk;

    ctl_t dut_ctl;
    assign dut_ctl = '{pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                       memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each instruction is a list of phases (phase number = visible state code).
    bit              m_idle = 1'b1;
    int              m_seq[$] = '{0, 1};
    int              m_idx = 0;
    bit [CNTW-1:0]   m_cnt = '0;

    function automatic iq_t prog(input logic [5:0] op);
        case (op)
            OP_LW:   return '{0, 1, 2, 3, 4};
            OP_SW:   return '{0, 1, 2, 5};
            OP_R:    return '{0, 1, 6, 7};
            OP_BEQ:  return '{0, 1, 8};
            OP_ADDI: return '{0, 1, 9, 10};
            OP_J:    return '{0, 1, 11};
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            default: return '{0, 1, 12};
`else
            default: return '{0, 1};
`endif
        endcase
    endfunction

    function automatic ctl_t ctl_of(input int ph, input logic mr);
        ctl_t c = '0;
        case (ph)
            0:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
            1:  c.alusrcb = 2'b11;
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3:  begin c.memread = 1; c.iord = 1; end
            4:  begin c.memtoreg = 1; c.regwrite = 1; end
            5:  begin c.memwrite = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            7:  begin c.regdst = 1; c.regwrite = 1; end
            8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcwritecond = 1; end
            9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            10: c.regwrite = 1;
            11: begin c.pcsrc = 2'b10; c.pcwrite = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic void retire();
        m_cnt  = m_cnt + 1'b1;
        m_seq  = '{0, 1};
        m_idx  = 0;
    endfunction

    initial forever begin
        int ph;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_idle = 1'b1;
            m_cnt  = '0;
            m_seq  = '{0, 1};
            m_idx  = 0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            ph = m_seq[m_idx];
            if (ph == 12 || ((ph == 0 || ph == 3 || ph == 5) && !mem_ready)) begin
            end else if (ph == 1) begin
                m_seq = prog(opcode);
                if (m_seq.size() == 2) retire();
                else m_idx = 2;
            end else if (m_idx == m_seq.size() - 1) begin
                retire();
            end else begin
                m_idx++;
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        int es;
        @(negedge clk);
        es = m_idle ? 15 : m_seq[m_idx];
        chk("state", 32'(state), 32'(es));
        chk("ctl", 32'(dut_ctl), 32'(m_idle ? ctl_t'('0) : ctl_of(es, mem_ready)));
        chk("count", 32'(instr_count), 32'(m_cnt));
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        chk("trap", 32'(trap), 32'(es == 12));
`endif
    end

    task automatic set_in(input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        @(negedge clk);
    endtask

    int lw_s[5]  = '{1, 2, 3, 4, 0};
    int rb_s[7]  = '{1, 6, 7, 0, 1, 8, 0};
    int sw_s[6]  = '{1, 2, 5, 5, 5, 5};
    int sw_m[6]  = '{1, 1, 0, 0, 0, 1};
    int j_s[5]   = '{0, 0, 1, 11, 0};
    int j_m[5]   = '{0, 1, 1, 1, 1};
    int j_ir[5]  = '{0, 1, 0, 0, 1};

    initial begin
        logic [5:0] ops[7];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BAD};
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        opcode    = OP_LW;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd15);
        chk("rst_ctl", 32'(dut_ctl), 32'd0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        set_in(1, OP_LW);
        chk("first_fetch", 32'(state), 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_in(1, OP_LW);
            chk("lw_state", 32'(state), 32'(lw_s[i]));
            chk("lw_wb", 32'({regwrite, memtoreg}), (i == 3) ? 32'd3 : 32'd0);
        end
        chk("lw_cnt", 32'(instr_count), 32'd1);

        for (int i = 0; i < 7; i++) begin
            set_in(1, (i < 3) ? OP_R : OP_BEQ);
            chk("rb_state", 32'(state), 32'(rb_s[i]));
            if (i == 1) chk("r_aluop", 32'(aluop), 32'd2);
            if (i == 5) chk("beq_ctl", 32'({aluop, pcwritecond}), 32'b011);
        end
        chk("rb_cnt", 32'(instr_count), 32'd3);

        for (int i = 0; i < 6; i++) begin
            set_in(sw_m[i][0], OP_SW);
            chk("sw_state", 32'(state), 32'(sw_s[i]));
            chk("sw_memwrite", 32'(memwrite), 32'(i >= 2));
        end
        set_in(0, OP_J);
        chk("sw_done", 32'(state), 32'd0);
        chk("sw_cnt", 32'(instr_count), 32'd4);
        chk("j_ir0", 32'(irwrite), 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_in(j_m[i][0], OP_J);
            chk("j_state", 32'(state), 32'(j_s[i]));
            chk("j_irwrite", 32'(irwrite), 32'(j_ir[i]));
            if (i == 3) chk("j_pc", 32'({pcwrite, pcsrc}), 32'b110);
        end
        chk("j_cnt", 32'(instr_count), 32'd5);

        set_in(1, OP_BAD);
        chk("bad_dec", 32'(state), 32'd1);
        set_in(1, OP_BAD);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        chk("bad_trap", 32'({trap, state}), 32'h1C);
        set_in(1, OP_BAD);
        chk("bad_hold", 32'({trap, state}), 32'h1C);
        chk("bad_cnt", 32'(instr_count), 32'd5);
`else
        chk("bad_fetch", 32'(state), 32'd0);
        chk("bad_cnt", 32'(instr_count), 32'd6);
`endif

        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        set_in(1, OP_LW);
        set_in(1, OP_LW);
        set_in(1, OP_LW);
        set_in(0, OP_LW);
        chk("mr_state", 32'(state), 32'd3);
        chk("mr_read", 32'(memread), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd15);
        chk("async_ctl", 32'(dut_ctl), 32'd0);
        chk("async_cnt", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        set_in(1, OP_LW);
        chk("rel_fetch", 32'(state), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (!m_idle && m_seq[m_idx] == 0) begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                opcode = ops[$urandom_range(0, 5)];
`else
                opcode = ops[$urandom_range(0, 6)];
                if (opcode == OP_BAD) opcode = 6'($urandom_range(0, 63));
`endif
            end
            mem_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
